// File: rtl/seven_seg_status_display_pkg.sv
// Shared segment patterns, run-state encoding and helpers for the seven-segment status display.
// Segments are active-low, bit0 = segment a .. bit6 = segment g.
package seven_seg_pkg;

    localparam logic [6:0] SEG_D0   = 7'b1000000;
    localparam logic [6:0] SEG_D1   = 7'b1111001;
    localparam logic [6:0] SEG_D2   = 7'b0100100;
    localparam logic [6:0] SEG_D3   = 7'b0110000;
    localparam logic [6:0] SEG_D4   = 7'b0011001;
    localparam logic [6:0] SEG_D5   = 7'b0010010;
    localparam logic [6:0] SEG_D6   = 7'b0000010;
    localparam logic [6:0] SEG_D7   = 7'b1111000;
    localparam logic [6:0] SEG_D8   = 7'b0000000;
    localparam logic [6:0] SEG_D9   = 7'b0010000;
    localparam logic [6:0] SEG_DARK = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    localparam logic [6:0] SEG_LO_O = 7'b0100011;
    localparam logic [6:0] SEG_UP_G = 7'b1000010;
    localparam logic [6:0] SEG_UP_E = 7'b0000110;
    localparam logic [6:0] SEG_UP_S = 7'b0010010;
    localparam logic [6:0] SEG_UP_U = 7'b1000001;
    localparam logic [6:0] SEG_UP_A = 7'b0001000;
    localparam logic [6:0] SEG_UP_P = 7'b0001100;
    localparam logic [6:0] SEG_LO_N = 7'b0101011;
    localparam logic [6:0] SEG_LO_D = 7'b0100001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GO    = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } run_state_t;

    function automatic logic [6:0] dig2seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_D0;
            4'd1:    return SEG_D1;
            4'd2:    return SEG_D2;
            4'd3:    return SEG_D3;
            4'd4:    return SEG_D4;
            4'd5:    return SEG_D5;
            4'd6:    return SEG_D6;
            4'd7:    return SEG_D7;
            4'd8:    return SEG_D8;
            4'd9:    return SEG_D9;
            default: return SEG_DARK;
        endcase
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/seven_seg_status_display_if.sv
// Control/status bundle between the run-control logic and the seven-segment display driver.
interface seven_seg_status_display_if #(
    parameter int VAL_W = 16
);
    logic             start_i;
    logic             pause_i;
    logic             finish_i;
    logic [VAL_W-1:0] value_i;
    logic             value_vld_i;
    logic             busy_o;
    logic             ovf_o;
    logic [1:0]       state_o;

    modport master (
        output start_i, pause_i, finish_i, value_i, value_vld_i,
        input  busy_o, ovf_o, state_o
    );

    modport slave (
        input  start_i, pause_i, finish_i, value_i, value_vld_i,
        output busy_o, ovf_o, state_o
    );
endinterface

// File: rtl/seven_seg_status_display_bin2bcd.sv
// Sequential double-dabble: one add-3/shift step per cycle, done pulses once after VAL_W steps.
// carry is sticky for a conversion and flags a value too wide for BCD_DIGITS digits.
module bin2bcd_seq #(
    parameter int VAL_W      = 16,
    parameter int BCD_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [VAL_W-1:0]        value,
    output logic                    done,
    output logic                    carry,
    output logic [4*BCD_DIGITS-1:0] bcd
);
    localparam int             CNT_W = $clog2(VAL_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VAL_W - 1);

    logic [VAL_W-1:0]        bin_reg;
    logic [4*BCD_DIGITS-1:0] bcd_reg;
    logic [4*BCD_DIGITS-1:0] adj;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    run_reg;
    logic                    done_reg;
    logic                    carry_reg;

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
        assign adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                              : bcd_reg[4*gi +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_reg   <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            run_reg   <= 1'b0;
            done_reg  <= 1'b0;
            carry_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                bin_reg   <= value;
                bcd_reg   <= '0;
                cnt_reg   <= '0;
                run_reg   <= 1'b1;
                carry_reg <= 1'b0;
            end else if (run_reg) begin
                bcd_reg   <= {adj[4*BCD_DIGITS-2:0], bin_reg[VAL_W-1]};
                bin_reg   <= bin_reg << 1;
                carry_reg <= carry_reg | adj[4*BCD_DIGITS-1];
                cnt_reg   <= cnt_reg + 1'b1;
                if (cnt_reg == LAST) begin
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done  = done_reg;
    assign carry = carry_reg;
    assign bcd   = bcd_reg;
endmodule

// File: rtl/seven_seg_status_display.sv
// Run-state message bank with PAUSE blink plus a decimal numeric bank with overflow dashes.
// Define SEVSEG_LZB_EN to blank leading zeros on the numeric bank.
module seven_seg_status_display
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VAL_W      = 16,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seven_seg_status_display_if.slave ctl,
    output logic [34:0]             hex_msg_o,
    output logic [7*NUM_DIGITS-1:0] hex_num_o
);
    localparam int          BCD_DIGITS = NUM_DIGITS + 1;
    localparam logic [63:0] NUM_MAX    = pow10(NUM_DIGITS) - 64'd1;
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);

    run_state_t state_reg, state_next;
    logic [34:0] msg_next;
    logic [31:0] blink_cnt_reg;
    logic        blink_dark_reg;

    logic                    busy_reg, ovf_reg, pend_vld_reg;
    logic [VAL_W-1:0]        conv_val_reg, pend_val_reg, conv_value;
    logic                    accept_new, accept_pend, conv_start, conv_done, conv_carry;
    logic [4*BCD_DIGITS-1:0] bcd;
    logic [7*NUM_DIGITS-1:0] num_next, num_rst;
    logic                    ovf_next;

    always_comb begin
        state_next = state_reg;
        msg_next   = {5{SEG_DASH}};
        case (state_reg)
            ST_IDLE: if (ctl.start_i) state_next = ST_GO;
            ST_GO: begin
                if (ctl.pause_i)       state_next = ST_PAUSE;
                else if (ctl.finish_i) state_next = ST_DONE;
                msg_next = {SEG_DARK, SEG_DARK, SEG_DARK, SEG_UP_G, SEG_LO_O};
            end
            ST_PAUSE: begin
                if (ctl.pause_i) state_next = ST_GO;
                msg_next = blink_dark_reg ? {5{SEG_DARK}}
                                          : {SEG_UP_P, SEG_UP_A, SEG_UP_U, SEG_UP_S, SEG_UP_E};
            end
            ST_DONE: msg_next = {SEG_DARK, SEG_LO_D, SEG_LO_O, SEG_LO_N, SEG_UP_E};
            default: state_next = ST_IDLE;
        endcase
    end

    // Blink phase only advances while PAUSE is both current and next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            hex_msg_o      <= {5{SEG_DASH}};
            blink_cnt_reg  <= '0;
            blink_dark_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            hex_msg_o <= msg_next;
            if (state_reg != ST_PAUSE || state_next != ST_PAUSE) begin
                blink_cnt_reg  <= '0;
                blink_dark_reg <= 1'b0;
            end else if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg  <= '0;
                blink_dark_reg <= ~blink_dark_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 32'd1;
            end
        end
    end

    // A value arriving on the update cycle bypasses the slot and supersedes it.
    assign accept_new  = ctl.value_vld_i && (!busy_reg || conv_done);
    assign accept_pend = pend_vld_reg && !busy_reg && !ctl.value_vld_i;
    assign conv_start  = accept_new || accept_pend;
    assign conv_value  = accept_new ? ctl.value_i : pend_val_reg;

    bin2bcd_seq #(
        .VAL_W      (VAL_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .value (conv_value),
        .done  (conv_done),
        .carry (conv_carry),
        .bcd   (bcd)
    );

    assign ovf_next = (64'(conv_val_reg) > NUM_MAX) || conv_carry
                      || (bcd[4*BCD_DIGITS-1 -: 4] != 4'd0);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_num_rst
`ifdef SEVSEG_LZB_EN
        assign num_rst[7*gi +: 7] = (gi == 0) ? SEG_D0 : SEG_DARK;
`else
        assign num_rst[7*gi +: 7] = SEG_D0;
`endif
    end

`ifdef SEVSEG_LZB_EN
    logic lead_zero;
`endif

    always_comb begin
        num_next = '0;
`ifdef SEVSEG_LZB_EN
        lead_zero = 1'b1;
`endif
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
`ifdef SEVSEG_LZB_EN
            if (lead_zero && k != 0 && bcd[4*k +: 4] == 4'd0) begin
                num_next[7*k +: 7] = SEG_DARK;
            end else begin
                num_next[7*k +: 7] = dig2seg(bcd[4*k +: 4]);
                lead_zero          = 1'b0;
            end
`else
            num_next[7*k +: 7] = dig2seg(bcd[4*k +: 4]);
`endif
        end
        if (ovf_next) num_next = {NUM_DIGITS{SEG_DASH}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            pend_vld_reg <= 1'b0;
            pend_val_reg <= '0;
            conv_val_reg <= '0;
            hex_num_o    <= num_rst;
        end else begin
            if (conv_start) begin
                busy_reg     <= 1'b1;
                conv_val_reg <= conv_value;
            end else if (conv_done) begin
                busy_reg <= 1'b0;
            end
            if (ctl.value_vld_i && !accept_new) begin
                pend_val_reg <= ctl.value_i;
                pend_vld_reg <= 1'b1;
            end else if (conv_start) begin
                pend_vld_reg <= 1'b0;
            end
            if (conv_done) begin
                ovf_reg   <= ovf_next;
                hex_num_o <= num_next;
            end
        end
    end

    assign ctl.busy_o  = busy_reg;
    assign ctl.ovf_o   = ovf_reg;
    assign ctl.state_o = state_reg;
endmodule

// File: tb/tb_seven_seg_status_display.sv
// Directed bench for seven_seg_status_display (NUM_DIGITS=4, VAL_W=16, BLINK_DIV=4, default build).
module tb_seven_seg_status_display;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [34:0] hex_msg;
    logic [27:0] hex_num;
    int          checks = 0;
    int          errors = 0;

    localparam logic [6:0] DARK = 7'b1111111;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [34:0] MSG_IDLE  = {5{DASH}};
    localparam logic [34:0] MSG_GO    = {DARK, DARK, DARK, 7'b1000010, 7'b0100011};
    localparam logic [34:0] MSG_PAUSE = {7'b0001100, 7'b0001000, 7'b1000001, 7'b0010010, 7'b0000110};
    localparam logic [34:0] MSG_DONE  = {DARK, 7'b0100001, 7'b0100011, 7'b0101011, 7'b0000110};
    localparam logic [34:0] MSG_DARK  = {5{DARK}};
    localparam logic [27:0] NUM_DASH  = {4{DASH}};

    always #5 clk = ~clk;

    seven_seg_status_display_if #(.VAL_W(16)) ctl ();

    seven_seg_status_display #(
        .NUM_DIGITS (4),
        .VAL_W      (16),
        .BLINK_DIV  (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctl       (ctl),
        .hex_msg_o (hex_msg),
        .hex_num_o (hex_num)
    );

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] num4(input int d3, input int d2, input int d1, input int d0);
        return {seg(d3), seg(d2), seg(d1), seg(d0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (ctl.state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", ctl.state_o); end
        checks++; if (ctl.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", ctl.busy_o); end
        checks++; if (ctl.ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ctl.ovf_o); end
        checks++; if (hex_msg !== MSG_IDLE) begin errors++; $display("FAIL reset_msg got %h want %h", hex_msg, MSG_IDLE); end
        checks++; if (hex_num !== num4(0, 0, 0, 0)) begin errors++; $display("FAIL reset_num got %h want %h", hex_num, num4(0, 0, 0, 0)); end
        rst_n = 1'b1;
        tick();
        checks++; if (hex_msg !== MSG_IDLE) begin errors++; $display("FAIL idle_msg got %h want %h", hex_msg, MSG_IDLE); end
        $display("reset done");
    endtask

    task automatic test_convert();
        ctl.value_i = 16'd1234; ctl.value_vld_i = 1'b1;
        tick();
        ctl.value_vld_i = 1'b0;
        checks++; if (ctl.busy_o !== 1'b1) begin errors++; $display("FAIL conv_busy_rise got %b want 1", ctl.busy_o); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (ctl.busy_o !== 1'b1 || hex_num !== num4(0, 0, 0, 0)) begin
                errors++;
                $display("FAIL conv_hold cycle %0d got busy=%b num=%h want busy=1 num=%h", k, ctl.busy_o, hex_num, num4(0, 0, 0, 0));
            end
        end
        tick();
        checks++; if (ctl.busy_o !== 1'b0) begin errors++; $display("FAIL conv_busy_fall got %b want 0", ctl.busy_o); end
        checks++; if (hex_num !== num4(1, 2, 3, 4)) begin errors++; $display("FAIL conv_1234 got %h want %h", hex_num, num4(1, 2, 3, 4)); end
        checks++; if (ctl.ovf_o !== 1'b0) begin errors++; $display("FAIL conv_ovf got %b want 0", ctl.ovf_o); end
        $display("convert 1234 -> num=%h", hex_num);
    endtask

    task automatic test_pending();
        bit seen7 = 1'b0;
        ctl.value_i = 16'd42; ctl.value_vld_i = 1'b1; tick();   // t=0
        ctl.value_vld_i = 1'b0; tick(); tick();                  // t=1,2
        ctl.value_i = 16'd7;  ctl.value_vld_i = 1'b1; tick();   // t=3
        ctl.value_vld_i = 1'b0; tick();                          // t=4
        ctl.value_i = 16'd99; ctl.value_vld_i = 1'b1; tick();   // t=5
        ctl.value_vld_i = 1'b0;
        for (int t = 6; t <= 40; t++) begin
            tick();
            if (hex_num === num4(0, 0, 0, 7)) seen7 = 1'b1;
            if (t == 16) begin checks++; if (hex_num !== num4(1, 2, 3, 4)) begin errors++; $display("FAIL pend_old t=%0d got %h want %h", t, hex_num, num4(1, 2, 3, 4)); end end
            if (t == 17) begin
                checks++; if (hex_num !== num4(0, 0, 4, 2)) begin errors++; $display("FAIL pend_42 got %h want %h", hex_num, num4(0, 0, 4, 2)); end
                checks++; if (ctl.busy_o !== 1'b0) begin errors++; $display("FAIL pend_busy_gap got %b want 0", ctl.busy_o); end
            end
            if (t == 18) begin checks++; if (ctl.busy_o !== 1'b1) begin errors++; $display("FAIL pend_start got %b want 1", ctl.busy_o); end end
            if (t == 34) begin checks++; if (hex_num !== num4(0, 0, 4, 2)) begin errors++; $display("FAIL pend_hold got %h want %h", hex_num, num4(0, 0, 4, 2)); end end
            if (t == 35) begin checks++; if (hex_num !== num4(0, 0, 9, 9)) begin errors++; $display("FAIL pend_99 got %h want %h", hex_num, num4(0, 0, 9, 9)); end end
        end
        checks++; if (seen7) begin errors++; $display("FAIL pend_7_shown got 1 want 0"); end
        $display("pending 42/7/99 -> num=%h", hex_num);
    endtask

    task automatic test_overflow();
        logic [15:0] vals[5];
        logic        exp_ovf[5];
        logic [27:0] exp_num[5];
        int          n;
        vals[0] = 16'd10000; exp_ovf[0] = 1'b1; exp_num[0] = NUM_DASH;
        vals[1] = 16'd9999;  exp_ovf[1] = 1'b0; exp_num[1] = num4(9, 9, 9, 9);
        vals[2] = 16'd0;     exp_ovf[2] = 1'b0; exp_num[2] = num4(0, 0, 0, 0);
        vals[3] = 16'd65535; exp_ovf[3] = 1'b1; exp_num[3] = NUM_DASH;
        vals[4] = 16'd10;    exp_ovf[4] = 1'b0; exp_num[4] = num4(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            ctl.value_i = vals[i]; ctl.value_vld_i = 1'b1;
            tick();
            ctl.value_vld_i = 1'b0;
            n = 0;
            while (ctl.busy_o === 1'b1 && n < 40) begin tick(); n++; end
            checks++; if (ctl.busy_o !== 1'b0) begin errors++; $display("FAIL ovf_timeout value=%0d got busy=%b want 0", vals[i], ctl.busy_o); end
            checks++; if (ctl.ovf_o !== exp_ovf[i]) begin errors++; $display("FAIL ovf_flag value=%0d got %b want %b", vals[i], ctl.ovf_o, exp_ovf[i]); end
            checks++; if (hex_num !== exp_num[i]) begin errors++; $display("FAIL ovf_num value=%0d got %h want %h", vals[i], hex_num, exp_num[i]); end
            $display("value %0d -> ovf=%b num=%h", vals[i], ctl.ovf_o, hex_num);
        end
    endtask

    task automatic test_reset_abort();
        ctl.value_i = 16'd5; ctl.value_vld_i = 1'b1; tick();
        ctl.value_vld_i = 1'b0; tick();
        ctl.value_i = 16'd8; ctl.value_vld_i = 1'b1; tick();
        ctl.value_vld_i = 1'b0; tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        checks++; if (ctl.busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", ctl.busy_o); end
        checks++; if (hex_num !== num4(0, 0, 0, 0)) begin errors++; $display("FAIL abort_num got %h want %h", hex_num, num4(0, 0, 0, 0)); end
        for (int k = 0; k < 40; k++) tick();
        checks++;
        if (hex_num !== num4(0, 0, 0, 0) || ctl.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet got busy=%b num=%h want busy=0 num=%h", ctl.busy_o, hex_num, num4(0, 0, 0, 0));
        end
        $display("reset abort -> num=%h", hex_num);
    endtask

    task automatic test_blink();
        logic [34:0] exp;
        ctl.start_i = 1'b1; tick(); ctl.start_i = 1'b0;
        checks++; if (ctl.state_o !== 2'd1) begin errors++; $display("FAIL blink_go_state got %0d want 1", ctl.state_o); end
        tick();
        checks++; if (hex_msg !== MSG_GO) begin errors++; $display("FAIL blink_go_msg got %h want %h", hex_msg, MSG_GO); end
        ctl.pause_i = 1'b1; tick(); ctl.pause_i = 1'b0;
        checks++; if (ctl.state_o !== 2'd2) begin errors++; $display("FAIL blink_pause_state got %0d want 2", ctl.state_o); end
        for (int i = 1; i <= 14; i++) begin
            tick();
            exp = ((((i - 1) / 4) % 2) == 0) ? MSG_PAUSE : MSG_DARK;
            checks++; if (hex_msg !== exp) begin errors++; $display("FAIL blink_phase i=%0d got %h want %h", i, hex_msg, exp); end
        end
        ctl.pause_i = 1'b1; tick(); ctl.pause_i = 1'b0;
        checks++; if (ctl.state_o !== 2'd1) begin errors++; $display("FAIL resume_state got %0d want 1", ctl.state_o); end
        checks++; if (hex_msg !== MSG_DARK) begin errors++; $display("FAIL resume_lag got %h want %h", hex_msg, MSG_DARK); end
        tick();
        checks++; if (hex_msg !== MSG_GO) begin errors++; $display("FAIL resume_go got %h want %h", hex_msg, MSG_GO); end
        ctl.pause_i = 1'b1; tick(); ctl.pause_i = 1'b0;
        tick();
        checks++; if (hex_msg !== MSG_PAUSE) begin errors++; $display("FAIL repause_visible got %h want %h", hex_msg, MSG_PAUSE); end
        $display("blink sequence done msg=%h", hex_msg);
    endtask

    task automatic test_fsm();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        ctl.pause_i = 1'b1; ctl.finish_i = 1'b1; tick(); ctl.pause_i = 1'b0; ctl.finish_i = 1'b0;
        checks++; if (ctl.state_o !== 2'd0) begin errors++; $display("FAIL fsm_idle_hold got %0d want 0", ctl.state_o); end
        ctl.start_i = 1'b1; tick(); ctl.start_i = 1'b0;
        checks++; if (ctl.state_o !== 2'd1) begin errors++; $display("FAIL fsm_start got %0d want 1", ctl.state_o); end
        ctl.pause_i = 1'b1; ctl.finish_i = 1'b1; tick(); ctl.pause_i = 1'b0; ctl.finish_i = 1'b0;
        checks++; if (ctl.state_o !== 2'd2) begin errors++; $display("FAIL fsm_pause_prio got %0d want 2", ctl.state_o); end
        ctl.finish_i = 1'b1; tick(); ctl.finish_i = 1'b0;
        checks++; if (ctl.state_o !== 2'd2) begin errors++; $display("FAIL fsm_finish_in_pause got %0d want 2", ctl.state_o); end
        ctl.pause_i = 1'b1; tick(); ctl.pause_i = 1'b0;
        checks++; if (ctl.state_o !== 2'd1) begin errors++; $display("FAIL fsm_resume got %0d want 1", ctl.state_o); end
        ctl.finish_i = 1'b1; tick(); ctl.finish_i = 1'b0;
        checks++; if (ctl.state_o !== 2'd3) begin errors++; $display("FAIL fsm_done got %0d want 3", ctl.state_o); end
        tick();
        checks++; if (hex_msg !== MSG_DONE) begin errors++; $display("FAIL fsm_done_msg got %h want %h", hex_msg, MSG_DONE); end
        ctl.start_i = 1'b1; tick(); ctl.start_i = 1'b0;
        checks++; if (ctl.state_o !== 2'd3) begin errors++; $display("FAIL fsm_done_start got %0d want 3", ctl.state_o); end
        ctl.pause_i = 1'b1; tick(); ctl.pause_i = 1'b0;
        checks++; if (ctl.state_o !== 2'd3) begin errors++; $display("FAIL fsm_done_pause got %0d want 3", ctl.state_o); end
        $display("fsm sequence done state=%0d", ctl.state_o);
    endtask

    initial begin
        rst_n = 1'b0;
        ctl.start_i = 1'b0; ctl.pause_i = 1'b0; ctl.finish_i = 1'b0;
        ctl.value_i = '0;   ctl.value_vld_i = 1'b0;
        test_reset();
        test_convert();
        test_pending();
        test_overflow();
        test_reset_abort();
        test_blink();
        test_fsm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
